tlul_host_seq: RTL and testbench
================================

# tlul_host_seq

Single-outstanding TileLink-UL initiator. It converts a simple valid/ready word-access request port into TL-UL A-channel transactions and returns D-channel results on a valid/ready response port. It drives the external host port of the system crossbar (`tl_ext_h2d` / `tl_ext_d2h`), giving a debug bridge or test sequencer the same view of memory and devices as the CPU. It includes a response timeout and stale-response filtering, so a hung target cannot lock up the host.

## Interface
- `TimeoutCycles`, default 1024: D-channel wait limit, counted in cycles after the A handshake. Legal range is 2..65535.
- `clk_i` in 1: system clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request ready.
- `req_we_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in 32: byte address; bits [1:0] are ignored (forced to 0 on the bus).
- `req_wdata_i` in 32: write data.
- `req_be_i` in 4: write byte enables; ignored for reads.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response ready.
- `rsp_rdata_o` out 32: read data; 0 for writes and on any error.
- `rsp_err_o` out 1: bus error, opcode mismatch, or illegal request.
- `rsp_timeout_o` out 1: no D response within `TimeoutCycles`.
- `busy_o` out 1: state is not IDLE.
- `tl_o` out `tlul_pkg::tl_h2d_t`: TL-UL host-to-device.
- `tl_i` in `tlul_pkg::tl_d2h_t`: TL-UL device-to-host.

## Operation
- **FSM states:** IDLE, A_SEND, D_WAIT, RSP.
- **IDLE:**
  - `req_ready_o`=1.
  - On handshake, latch we/addr/wdata/be and increment the 8-bit source counter `src_q` (wraps 255→0).
  - If `req_we_i`=1 and `req_be_i`=0: go to RSP with err=1 and issue no bus access.
  - Otherwise go to A_SEND.
- **A_SEND:**
  - `a_valid`=1 and all A fields held stable until `a_ready`.
  - `a_size`=2, `a_source`=`src_q`, `a_address`={addr[31:2],2'b00}, `a_param`=0, `a_user`=default.
  - Read: opcode Get(4), `a_mask`=4'hF, `a_data`=0.
  - Write: opcode PutFullData(0) if be=4'hF, otherwise PutPartialData(1); `a_mask`=be.
  - On `a_valid`&`a_ready`, go to D_WAIT and clear the timeout counter.
  - No timeout applies in A_SEND (TL-UL forbids withdrawing `a_valid`).
- **D_WAIT:**
  - A D beat with `d_source`==`src_q` is matched. Capture `d_data` (reads only) and go to RSP.
  - err = `d_error` | (read & `d_opcode`≠AccessAckData(1)) | (write & `d_opcode`≠AccessAck(0)). If err=1, rdata=0.
  - If the counter reaches `TimeoutCycles`-1 without a match, go to RSP with timeout=1, err=0, rdata=0.
  - A match arriving on the same cycle as expiry wins: normal response, timeout=0.
- **RSP:**
  - `rsp_valid_o`=1 with fields stable until `rsp_ready_i`, then return to IDLE.
- **`d_ready`:** 1 in every state out of reset.
  - Any D beat that is not a D_WAIT match is accepted and discarded silently. This covers late responses to timed-out transactions and wrong sources.
  - Discarded beats cause no state change.
- **Reset (asynchronous, any state):**
  - Enter IDLE with `src_q`=0 and counter=0.
  - All `tl_o` fields = 0 except `d_ready`=1.
  - `req_ready_o`=1 after reset deasserts.
  - `rsp_valid_o`=0, `rsp_*` fields=0, `busy_o`=0.
  - In-flight transactions are abandoned; their D beats are discarded by source mismatch or state.

## Timing
- Request handshake at cycle N → `a_valid` registered high at N+1.
- A handshake at cycle M → matched D can be accepted from cycle M+1.
- D accepted at cycle K → `rsp_valid_o` high at K+1.
- Minimum round trip with zero-wait target: handshake N, A at N+1, D at N+2, rsp at N+3, ready for a new request at N+4 after `rsp_ready_i`.
- Timeout: D_WAIT entered at M+1, and `rsp_valid_o` with timeout rises at M+1+`TimeoutCycles`.
- All outputs are registered except `req_ready_o` and `busy_o`, which decode directly from state.

## Test plan
- **Read, zero-wait responder:** req read `0x8000_0004` → A Get, mask F, size 2, source 1. D AccessAckData with data `0xDEADBEEF` → `rsp_rdata_o`=`0xDEADBEEF`, err=0, rsp 3 cycles after the request handshake.
- **Partial write and backpressure:** write be=4'b0011, `a_ready` held low 5 cycles → PutPartialData, mask 3, A fields stable for all 5 cycles. D AccessAck → err=0, rdata=0.
- **Errors:** `d_error`=1 on a read → err=1, rdata=0. Write with be=0 → err=1 next cycle with no `a_valid` ever asserted. Read answered with AccessAck → err=1.
- **Timeout and stale response:** `TimeoutCycles`=16, no D → timeout=1 exactly 16 cycles after D_WAIT entry. Then issue a second read (source 2) and inject the late source-1 D beat before the real one → late beat discarded, second response carries the source-2 data.
- **Source wrap:** 256 back-to-back reads → source goes 1…255, then 0 on the 256th; all 256 complete without error.
- **Reset mid-operation:** assert `rst_ni` low in A_SEND and in RSP → `a_valid`=0 and `rsp_valid_o`=0 asynchronously. After release, `req_ready_o`=1 and the next request uses source 1.

Source files
------------

// File: rtl/tlul_pkg.sv
// TL-UL channel structs and opcodes for a 32-bit data bus with an 8-bit source ID.
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    localparam logic [7:0] TlAUserDefault = 8'h00;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [7:0]  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [7:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_host_seq.sv
// Single-outstanding TL-UL initiator: req -> A at +1, D match -> rsp at +1; A held until a_ready,
// rsp held until rsp_ready, req accepted only in IDLE; D_WAIT bounded by TimeoutCycles.
module tlul_host_seq #(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [31:0]          req_addr_i,
    input  logic [31:0]          req_wdata_i,
    input  logic [3:0]           req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,
    output logic                 busy_o,
    output tlul_pkg::tl_h2d_t    tl_o,
    input  tlul_pkg::tl_d2h_t    tl_i
);

    localparam logic [15:0] CntLast = 16'(TimeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT, RSP} state_e;

    state_e      state_q, state_d;
    logic [7:0]  src_q, src_d;
    logic        we_q, we_d;
    logic [15:0] cnt_q, cnt_d;
    logic        a_valid_q, a_valid_d;
    logic [2:0]  a_opcode_q, a_opcode_d;
    logic [1:0]  a_size_q, a_size_d;
    logic [31:0] a_address_q, a_address_d;
    logic [3:0]  a_mask_q, a_mask_d;
    logic [31:0] a_data_q, a_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    logic d_match, d_err;
    logic unused_d_fields;

    assign unused_d_fields = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        we_d          = we_q;
        cnt_d         = cnt_q;
        a_valid_d     = a_valid_q;
        a_opcode_d    = a_opcode_q;
        a_size_d      = a_size_q;
        a_address_d   = a_address_q;
        a_mask_d      = a_mask_q;
        a_data_d      = a_data_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        req_ready_o = (state_q == IDLE);
        busy_o      = (state_q != IDLE);

        // d_ready is always high, so any beat that is not this match is silently dropped
        d_match = tl_i.d_valid && (state_q == D_WAIT) && (tl_i.d_source == src_q);
        d_err   = tl_i.d_error |
                  (we_q ? (tl_i.d_opcode != tlul_pkg::AccessAck)
                        : (tl_i.d_opcode != tlul_pkg::AccessAckData));

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    src_d       = src_q + 8'd1;
                    we_d        = req_we_i;
                    a_size_d    = 2'd2;
                    a_address_d = {req_addr_i[31:2], 2'b00};
                    a_mask_d    = req_we_i ? req_be_i : 4'hF;
                    a_data_d    = req_we_i ? req_wdata_i : 32'h0;
                    a_opcode_d  = !req_we_i         ? tlul_pkg::Get :
                                  (req_be_i == 4'hF) ? tlul_pkg::PutFullData
                                                     : tlul_pkg::PutPartialData;
                    if (req_we_i && (req_be_i == 4'h0)) begin
                        state_d       = RSP;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_rdata_d   = 32'h0;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        state_d   = A_SEND;
                        a_valid_d = 1'b1;
                    end
                end
            end
            A_SEND: begin
                if (tl_i.a_ready) begin
                    a_valid_d = 1'b0;
                    cnt_d     = 16'h0;
                    state_d   = D_WAIT;
                end
            end
            D_WAIT: begin
                if (d_match) begin
                    state_d       = RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = d_err;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!we_q && !d_err) ? tl_i.d_data : 32'h0;
                end else if (cnt_q == CntLast) begin
                    state_d       = RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = 32'h0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            src_q         <= 8'h0;
            we_q          <= 1'b0;
            cnt_q         <= 16'h0;
            a_valid_q     <= 1'b0;
            a_opcode_q    <= 3'h0;
            a_size_q      <= 2'h0;
            a_address_q   <= 32'h0;
            a_mask_q      <= 4'h0;
            a_data_q      <= 32'h0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            we_q          <= we_d;
            cnt_q         <= cnt_d;
            a_valid_q     <= a_valid_d;
            a_opcode_q    <= a_opcode_d;
            a_size_q      <= a_size_d;
            a_address_q   <= a_address_d;
            a_mask_q      <= a_mask_d;
            a_data_q      <= a_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid_q;
        tl_o.a_opcode  = a_opcode_q;
        tl_o.a_param   = 3'h0;
        tl_o.a_size    = a_size_q;
        tl_o.a_source  = src_q;
        tl_o.a_address = a_address_q;
        tl_o.a_mask    = a_mask_q;
        tl_o.a_data    = a_data_q;
        tl_o.a_user    = tlul_pkg::TlAUserDefault;
        tl_o.d_ready   = 1'b1;
    end

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_tlul_host_seq.sv
// Directed bench for tlul_host_seq with TimeoutCycles=16; tasks drive stimulus and check inline.
module tb_tlul_host_seq;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready_o;
    logic              req_we = 1'b0;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic [3:0]        req_be = 4'h0;
    logic              rsp_valid_o;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic              rsp_timeout_o;
    logic              busy_o;
    tlul_pkg::tl_h2d_t tl_o;
    tlul_pkg::tl_d2h_t tl_i;

    int n_tests = 0;
    int n_fail  = 0;

    tlul_host_seq #(.TimeoutCycles(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_be_i     (req_be),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .busy_o       (busy_o),
        .tl_o         (tl_o),
        .tl_i         (tl_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        for (int i = 0; i < 40 && !req_ready_o; i++) tick();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
    endtask

    task automatic d_beat(input logic [7:0] src, input logic [2:0] op, input logic err,
                          input logic [31:0] dat);
        tl_i.d_valid  = 1'b1;
        tl_i.d_source = src;
        tl_i.d_opcode = op;
        tl_i.d_error  = err;
        tl_i.d_data   = dat;
        tick();
        tl_i.d_valid  = 1'b0;
        tl_i.d_error  = 1'b0;
        tl_i.d_data   = 32'h0;
    endtask

    task automatic ack_rsp;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        tlul_pkg::tl_h2d_t exp;
        exp = '0;
        exp.d_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (tl_o !== exp) begin n_fail++; $display("FAIL rst_tl_o: got %h want %h", tl_o, exp); end
        n_tests++;
        if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o, busy_o} !== 36'h0) begin
            n_fail++; $display("FAIL rst_rsp: got v%b e%b t%b d%h b%b want all 0",
                               rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o, busy_o);
        end
        #1;
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready_o); end
    endtask

    task automatic test_read;
        tl_i.a_ready = 1'b1;
        issue(1'b0, 32'h8000_0004, 32'h0, 4'h0);
        n_tests++;
        if ({tl_o.a_valid, tl_o.a_opcode, tl_o.a_size, tl_o.a_source, tl_o.a_address, tl_o.a_mask, tl_o.a_data, tl_o.a_param}
            !== {1'b1, 3'h4, 2'd2, 8'd1, 32'h8000_0004, 4'hF, 32'h0, 3'h0}) begin
            n_fail++; $display("FAIL rd_a_fields: got v%b op%h sz%h src%h adr%h m%h d%h want v1 op4 sz2 src01 adr80000004 mF d0",
                               tl_o.a_valid, tl_o.a_opcode, tl_o.a_size, tl_o.a_source, tl_o.a_address, tl_o.a_mask, tl_o.a_data);
        end
        tick();
        n_tests++;
        if ({tl_o.a_valid, rsp_valid_o} !== 2'b00) begin
            n_fail++; $display("FAIL rd_after_a: got a_valid %b rsp_valid %b want 0 0", tl_o.a_valid, rsp_valid_o);
        end
        d_beat(8'd1, tlul_pkg::AccessAckData, 1'b0, 32'hDEAD_BEEF);
        n_tests++;
        if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o} !== {3'b100, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL rd_rsp: got v%b e%b t%b d%h want v1 e0 t0 dDEADBEEF",
                               rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o);
        end
        ack_rsp();
        n_tests++;
        if ({rsp_valid_o, req_ready_o, busy_o} !== 3'b010) begin
            n_fail++; $display("FAIL rd_idle: got rsp_valid %b req_ready %b busy %b want 0 1 0",
                               rsp_valid_o, req_ready_o, busy_o);
        end
    endtask

    task automatic test_partial_write;
        tl_i.a_ready = 1'b0;
        issue(1'b1, 32'h0000_1236, 32'hA5A5_1234, 4'b0011);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({tl_o.a_valid, tl_o.a_opcode, tl_o.a_mask, tl_o.a_address, tl_o.a_data, tl_o.a_source}
                !== {1'b1, 3'h1, 4'h3, 32'h0000_1234, 32'hA5A5_1234, 8'd2}) begin
                n_fail++; $display("FAIL wr_hold_%0d: got v%b op%h m%h adr%h d%h src%h want v1 op1 m3 adr00001234 dA5A51234 src02",
                                   i, tl_o.a_valid, tl_o.a_opcode, tl_o.a_mask, tl_o.a_address, tl_o.a_data, tl_o.a_source);
            end
            tick();
        end
        tl_i.a_ready = 1'b1;
        tick();
        n_tests++;
        if (tl_o.a_valid !== 1'b0) begin n_fail++; $display("FAIL wr_a_drop: got %b want 0", tl_o.a_valid); end
        d_beat(8'd2, tlul_pkg::AccessAck, 1'b0, 32'hFFFF_FFFF);
        n_tests++;
        if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o} !== {3'b100, 32'h0}) begin
            n_fail++; $display("FAIL wr_rsp: got v%b e%b t%b d%h want v1 e0 t0 d0",
                               rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o);
        end
        ack_rsp();
    endtask

    task automatic test_errors;
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        tick();
        d_beat(8'd3, tlul_pkg::AccessAckData, 1'b1, 32'h1234_5678);
        n_tests++;
        if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b11, 32'h0}) begin
            n_fail++; $display("FAIL err_derr: got v%b e%b d%h want v1 e1 d0", rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        ack_rsp();

        issue(1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0);
        n_tests++;
        if ({tl_o.a_valid, rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o} !== {4'b0110, 32'h0}) begin
            n_fail++; $display("FAIL err_be0: got a_valid %b v%b e%b t%b d%h want a_valid 0 v1 e1 t0 d0",
                               tl_o.a_valid, rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o);
        end
        ack_rsp();
        n_tests++;
        if (tl_o.a_valid !== 1'b0) begin n_fail++; $display("FAIL err_be0_noa: got %b want 0", tl_o.a_valid); end

        issue(1'b0, 32'h0000_0030, 32'h0, 4'h0);
        n_tests++;
        if (tl_o.a_source !== 8'd5) begin n_fail++; $display("FAIL err_src: got %h want 05", tl_o.a_source); end
        tick();
        d_beat(8'd5, tlul_pkg::AccessAck, 1'b0, 32'h55AA_55AA);
        n_tests++;
        if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b11, 32'h0}) begin
            n_fail++; $display("FAIL err_opcode: got v%b e%b d%h want v1 e1 d0", rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        ack_rsp();
    endtask

    task automatic test_timeout_stale;
        int early;
        apply_reset();
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        tick();
        early = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rsp_valid_o) early++;
        end
        n_tests++;
        if (early !== 0) begin n_fail++; $display("FAIL to_early: got %0d early cycles want 0", early); end
        tick();
        n_tests++;
        if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o} !== {3'b101, 32'h0}) begin
            n_fail++; $display("FAIL to_rsp: got v%b e%b t%b d%h want v1 e0 t1 d0",
                               rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o);
        end
        ack_rsp();

        issue(1'b0, 32'h0000_0044, 32'h0, 4'h0);
        tick();
        d_beat(8'd1, tlul_pkg::AccessAckData, 1'b0, 32'hBAD0_BAD0);
        n_tests++;
        if ({rsp_valid_o, busy_o} !== 2'b01) begin
            n_fail++; $display("FAIL stale_drop: got rsp_valid %b busy %b want 0 1", rsp_valid_o, busy_o);
        end
        d_beat(8'd2, tlul_pkg::AccessAckData, 1'b0, 32'h600D_600D);
        n_tests++;
        if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o} !== {3'b100, 32'h600D_600D}) begin
            n_fail++; $display("FAIL stale_real: got v%b e%b t%b d%h want v1 e0 t0 d600D600D",
                               rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o);
        end
        ack_rsp();

        issue(1'b0, 32'h0000_0048, 32'h0, 4'h0);
        tick();
        for (int i = 0; i < 15; i++) tick();
        d_beat(8'd3, tlul_pkg::AccessAckData, 1'b0, 32'h0BAD_F00D);
        n_tests++;
        if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o} !== {3'b100, 32'h0BAD_F00D}) begin
            n_fail++; $display("FAIL to_tie: got v%b e%b t%b d%h want v1 e0 t0 d0BADF00D",
                               rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o);
        end
        ack_rsp();
    endtask

    task automatic test_source_wrap;
        logic [7:0]  exp_src;
        logic [31:0] exp_dat;
        apply_reset();
        tl_i.a_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            exp_src = 8'(i + 1);
            exp_dat = 32'hC0DE_0000 ^ 32'(i);
            issue(1'b0, 32'(i) << 2, 32'h0, 4'h0);
            n_tests++;
            if ({tl_o.a_valid, tl_o.a_source} !== {1'b1, exp_src}) begin
                n_fail++; $display("FAIL wrap_src_%0d: got v%b src%h want v1 src%h", i, tl_o.a_valid, tl_o.a_source, exp_src);
            end
            tick();
            d_beat(exp_src, tlul_pkg::AccessAckData, 1'b0, exp_dat);
            n_tests++;
            if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o} !== {3'b100, exp_dat}) begin
                n_fail++; $display("FAIL wrap_rsp_%0d: got v%b e%b t%b d%h want v1 e0 t0 d%h",
                                   i, rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o, exp_dat);
            end
            ack_rsp();
        end
    endtask

    task automatic test_reset_mid;
        tl_i.a_ready = 1'b0;
        issue(1'b0, 32'h0000_0050, 32'h0, 4'h0);
        n_tests++;
        if (tl_o.a_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_a: got %b want 1", tl_o.a_valid); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({tl_o.a_valid, busy_o, tl_o.d_ready} !== 3'b001) begin
            n_fail++; $display("FAIL mid_rst_a: got a_valid %b busy %b d_ready %b want 0 0 1", tl_o.a_valid, busy_o, tl_o.d_ready);
        end
        #1;
        rst_n = 1'b1;
        tl_i.a_ready = 1'b1;
        tick();
        n_tests++;
        if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_ready_a: got %b want 1", req_ready_o); end

        issue(1'b0, 32'h0000_0054, 32'h0, 4'h0);
        n_tests++;
        if (tl_o.a_source !== 8'd1) begin n_fail++; $display("FAIL mid_src_a: got %h want 01", tl_o.a_source); end
        tick();
        d_beat(8'd1, tlul_pkg::AccessAckData, 1'b0, 32'h1111_2222);
        n_tests++;
        if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre_rsp: got %b want 1", rsp_valid_o); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o} !== 35'h0) begin
            n_fail++; $display("FAIL mid_rst_rsp: got v%b e%b t%b d%h want all 0",
                               rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o);
        end
        #1;
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_ready_rsp: got %b want 1", req_ready_o); end
        issue(1'b0, 32'h0000_0058, 32'h0, 4'h0);
        n_tests++;
        if (tl_o.a_source !== 8'd1) begin n_fail++; $display("FAIL mid_src_rsp: got %h want 01", tl_o.a_source); end
        tick();
        d_beat(8'd1, tlul_pkg::AccessAckData, 1'b0, 32'h0000_0077);
        n_tests++;
        if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b10, 32'h0000_0077}) begin
            n_fail++; $display("FAIL mid_after: got v%b e%b d%h want v1 e0 d00000077", rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        ack_rsp();
    endtask

    initial begin
        tl_i = '0;
        tl_i.a_ready = 1'b1;
        test_reset();
        test_read();
        test_partial_write();
        test_errors();
        test_timeout_stale();
        test_source_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
